color_dwell_logger: RTL and testbench
=====================================

COLOR_DWELL_LOGGER -- requirements
Module: color_dwell_logger

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 8, the width of the dwell counter.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of event FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in, input, 2 bits: colour code from the upstream colour FSM output (2'h1 = Blue, 2'h2 = Red, 2'h0 and 2'h3 invalid).
REQ-006 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head record.
REQ-007 The block SHALL have port out_valid, output, 1 bit: a record is available at the FIFO head.
REQ-008 The block SHALL have port out_data, output, CNT_WIDTH+2 bits: {colour code [CNT_WIDTH+1:CNT_WIDTH], dwell cycles [CNT_WIDTH-1:0]}.
REQ-009 The block SHALL have port err, output, 1 bit: sticky flag, set when an invalid code is sampled.
REQ-010 The block SHALL have port drop, output, 1 bit: sticky flag, set when a record is lost because the FIFO is full.

Function
REQ-011 The block SHALL implement a tracking FSM with two states: IDLE (no valid code seen yet) and TRACK.
REQ-012 In IDLE, when in is valid: last_code <= in, dwell <= 1, next state TRACK; when in is invalid: err <= 1, stay in IDLE.
REQ-013 In TRACK, when in equals last_code: dwell <= dwell + 1, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-014 In TRACK, when in is valid and differs from last_code: push {last_code, dwell}; then last_code <= in and dwell <= 1, all in the same cycle.
REQ-015 In TRACK, when in is invalid: err <= 1; last_code and dwell hold; no push.
REQ-016 A push SHALL become visible on out_valid/out_data after the same clock edge that samples the changed code (1-cycle latency).
REQ-017 out_valid SHALL equal FIFO not-empty; out_data SHALL be the head entry; out_data is don't-care when out_valid=0.
REQ-018 A pop SHALL occur when out_valid && out_ready; out_data SHALL hold stable while out_valid && !out_ready.
REQ-019 Push while full and no pop: the record is discarded, drop <= 1, FIFO contents unchanged.
REQ-020 Push while full with a simultaneous pop: the push is accepted, occupancy stays DEPTH, drop is not set.
REQ-021 Push and pop while not full: both take effect, occupancy unchanged.
REQ-022 Push and pop while empty: the push is accepted, out_valid=1 next cycle; there is no fall-through bypass.
REQ-023 FIFO read/write pointers SHALL wrap modulo DEPTH, with an extra MSB to distinguish full from empty.
REQ-024 err and drop SHALL clear only on reset.

Reset
REQ-025 When rst=0, the block SHALL asynchronously force: state=IDLE, last_code=0, dwell=0, FIFO empty, out_valid=0, err=0, drop=0.
REQ-026 Reset asserted mid-operation SHALL discard all queued records and the in-progress dwell count; after release the first valid code starts a fresh dwell count of 1.
REQ-027 Release of rst SHALL take effect at the first rising clk edge after deassertion; no push occurs on that edge unless REQ-014 is met from TRACK.

Verification
REQ-028 Reset, then in=1 for 3 cycles then in=2, out_ready=1 -> one record {2'h1, 8'd3}, out_valid high for 1 cycle, err=0.
REQ-029 in=1 held for 300 cycles then in=2 -> record {2'h1, 8'd255} (saturated).
REQ-030 out_ready=0, 5 alternating changes with DEPTH=4 -> 4 records in order, 5th dropped, drop=1; draining yields exactly 4 records, then out_valid=0.
REQ-031 FIFO full, out_ready=1 and a code change in the same cycle -> head popped, new record appended, drop stays 0, order preserved.
REQ-032 in=2, then in=3 for 2 cycles, then in=2 for 1 cycle, then in=1 -> err=1, single record {2'h2, 8'd2} (invalid cycles not counted).
REQ-033 rst pulsed low while 2 records are queued and dwell=7 -> out_valid=0 immediately; after release, in=2 for 4 cycles then in=1 -> record {2'h2, 8'd4}.

Source files
------------

// File: rtl/color_dwell_logger.sv
// Colour dwell logger: measures how long each valid colour code is held
// and queues {code, dwell} records in a small FIFO for a consumer.
//
// Ports:
//   clk        - clock, all state updates on its rising edge
//   rst        - asynchronous active-low reset
//   in[1:0]    - colour code (1 = Blue, 2 = Red, 0/3 invalid)
//   out_ready  - consumer accepts the head record
//   out_valid  - a record is available at the FIFO head
//   out_data   - head record {code, dwell cycles}
//   err        - sticky, an invalid code was sampled
//   drop       - sticky, a record was lost because the FIFO was full
module color_dwell_logger #(
    parameter int CNT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           in,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [CNT_WIDTH+1:0] out_data,
    output logic                 err,
    output logic                 drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, TRACK} state_t;

    state_t               state, state_n;
    logic [1:0]           last_code, code_n;
    logic [CNT_WIDTH-1:0] dwell, dwell_n;
    logic                 push, set_err;
    logic                 code_ok;

    logic [CNT_WIDTH+1:0] mem [DEPTH];
    logic [AW:0]          wptr, rptr;
    logic                 empty, full, pop, wr_en, set_drop;

    assign code_ok = (in == 2'h1) || (in == 2'h2);

    always_comb begin
        state_n = state;
        code_n  = last_code;
        dwell_n = dwell;
        push    = 1'b0;
        set_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (code_ok) begin
                    code_n  = in;
                    dwell_n = CNT_ONE;
                    state_n = TRACK;
                end else begin
                    set_err = 1'b1;
                end
            end
            TRACK: begin
                if (!code_ok) begin
                    set_err = 1'b1;
                end else if (in == last_code) begin
                    // saturate rather than wrap
                    dwell_n = (dwell == CNT_MAX) ? dwell : dwell + CNT_ONE;
                end else begin
                    push    = 1'b1;
                    code_n  = in;
                    dwell_n = CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Extra pointer MSB separates full from empty when the indices match
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop      = !empty && out_ready;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign wr_en    = push && (!full || pop);
    assign set_drop = push && full && !pop;

    assign out_valid = !empty;
    assign out_data  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_code <= 2'h0;
            dwell     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            err       <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state     <= state_n;
            last_code <= code_n;
            dwell     <= dwell_n;
            if (wr_en) wptr <= wptr + PTR_ONE;
            if (pop)   rptr <= rptr + PTR_ONE;
            if (set_err)  err  <= 1'b1;
            if (set_drop) drop <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= {last_code, dwell};
    end

endmodule

// File: tb/tb_color_dwell_logger.sv
// Self-checking bench for color_dwell_logger: a run-length model with a
// record queue is compared against the DUT every cycle, plus literal checks.
module tb_color_dwell_logger;

    localparam int CW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    in = 2'h0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [CW+1:0] out_data;
    logic          err;
    logic          drop;

    int checks = 0;
    int errors = 0;

    color_dwell_logger #(.CNT_WIDTH(CW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in(in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .err(err),
        .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: code of the current run (0 = none yet) and its unbounded length
    logic [CW+1:0] q [$];
    logic [1:0]    cur;
    int            run;
    logic          m_err, m_drop;

    always @(posedge clk or negedge rst) begin
        logic          do_pop, do_push;
        logic [CW+1:0] rec;
        if (!rst) begin
            q.delete();
            cur    = 2'h0;
            run    = 0;
            m_err  = 1'b0;
            m_drop = 1'b0;
        end else begin
            do_pop  = (q.size() > 0) && out_ready;
            do_push = 1'b0;
            rec     = '0;
            if (in == 2'h1 || in == 2'h2) begin
                if (cur == 2'h0) begin
                    cur = in;
                    run = 1;
                end else if (in == cur) begin
                    run++;
                end else begin
                    do_push = 1'b1;
                    rec     = {cur, (run > 255) ? 8'hFF : 8'(run)};
                    cur     = in;
                    run     = 1;
                end
            end else begin
                m_err = 1'b1;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < DEPTH) q.push_back(rec);
                else m_drop = 1'b1;
            end
        end
    end

    // Per-cycle compare and log of records the consumer takes
    logic [CW+1:0] got [$];
    int            vcount = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) chk("data", 32'(out_data), 32'(q[0]));
            chk("err", 32'(err), 32'(m_err));
            chk("drop", 32'(drop), 32'(m_drop));
            if (out_valid) vcount++;
            if (out_valid && out_ready) got.push_back(out_data);
        end
    end

    task automatic drive(input logic [1:0] code, input int n);
        in = code;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        out_ready = 1'b1;
        while (out_valid && k < limit) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("drain_timeout", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int base, vbase;

        // Reset state
        #12;
        do_reset();

        // Three Blue cycles then Red
        base = got.size();
        vbase = vcount;
        out_ready = 1'b1;
        drive(2'h1, 3);
        drive(2'h2, 4);
        chk("r028_cnt", 32'(got.size() - base), 32'd1);
        chk("r028_rec", 32'(got[base]), 32'h103);
        chk("r028_vcyc", 32'(vcount - vbase), 32'd1);
        chk("r028_err", 32'(err), 32'd0);

        // Saturating dwell
        do_reset();
        base = got.size();
        out_ready = 1'b1;
        drive(2'h1, 300);
        drive(2'h2, 3);
        chk("r029_rec", 32'(got[base]), 32'h1FF);

        // Overflow with consumer stalled
        do_reset();
        base = got.size();
        out_ready = 1'b0;
        drive(2'h1, 1);
        drive(2'h2, 2);
        drive(2'h1, 3);
        drive(2'h2, 4);
        drive(2'h1, 5);
        drive(2'h2, 1);
        chk("r030_drop", 32'(drop), 32'd1);
        chk("r030_full", 32'(out_valid), 32'd1);
        drain(20);
        chk("r030_cnt", 32'(got.size() - base), 32'd4);
        chk("r030_r0", 32'(got[base]), 32'h101);
        chk("r030_r1", 32'(got[base+1]), 32'h202);
        chk("r030_r2", 32'(got[base+2]), 32'h103);
        chk("r030_r3", 32'(got[base+3]), 32'h204);

        // Full FIFO with simultaneous pop and push
        do_reset();
        base = got.size();
        out_ready = 1'b0;
        drive(2'h1, 1);
        drive(2'h2, 2);
        drive(2'h1, 3);
        drive(2'h2, 4);
        drive(2'h1, 2);
        out_ready = 1'b1;
        in = 2'h2;
        drain(20);
        chk("r031_drop", 32'(drop), 32'd0);
        chk("r031_cnt", 32'(got.size() - base), 32'd5);
        chk("r031_r0", 32'(got[base]), 32'h101);
        chk("r031_r3", 32'(got[base+3]), 32'h204);
        chk("r031_r4", 32'(got[base+4]), 32'h102);

        // Invalid codes set err and are not counted
        do_reset();
        base = got.size();
        out_ready = 1'b1;
        drive(2'h2, 1);
        drive(2'h3, 2);
        drive(2'h2, 1);
        drive(2'h1, 3);
        chk("r032_err", 32'(err), 32'd1);
        chk("r032_cnt", 32'(got.size() - base), 32'd1);
        chk("r032_rec", 32'(got[base]), 32'h202);

        // Reset while records are queued mid-dwell
        do_reset();
        out_ready = 1'b0;
        drive(2'h1, 1);
        drive(2'h2, 1);
        drive(2'h1, 7);
        chk("r033_pre", 32'(out_valid), 32'd1);
        do_reset();
        base = got.size();
        out_ready = 1'b1;
        drive(2'h2, 4);
        drive(2'h1, 3);
        chk("r033_cnt", 32'(got.size() - base), 32'd1);
        chk("r033_rec", 32'(got[base]), 32'h204);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
